// File: rtl/falu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : falu_issue_ctrl
// Description : Issue/sequencing controller for the fixed-latency float ALU
//               (FADD.S/FSUB.S). Starts FALU ops from EX, times the result,
//               presents it on the shared FP writeback port and raises
//               pipeline stalls for structural, RAW and WAW hazards against
//               the single pending FP destination.
// Ports       : clk, rst_n                 clock / async active-low reset
//               ex_valid, ex_falu_en,
//               ex_rd, ex_fp_wr, flush     EX-stage instruction info
//               id_fp_rs1_en, id_fp_rs2_en,
//               id_rs1, id_rs2             ID-stage FP source operands
//               wb_ready                   writeback port accepts result
//               falu_start                 FALU samples operands this cycle
//               falu_busy                  issued op not yet written back
//               wb_valid, wb_rd            pending result and its index
//               stall                      hold IF/ID/EX this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module falu_issue_ctrl #(
    parameter int FALU_LAT = 3,
    parameter int RD_W     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_falu_en,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_fp_wr,
    input  logic            flush,
    input  logic            id_fp_rs1_en,
    input  logic            id_fp_rs2_en,
    input  logic [RD_W-1:0] id_rs1,
    input  logic [RD_W-1:0] id_rs2,
    input  logic            wb_ready,
    output logic            falu_start,
    output logic            falu_busy,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic            stall
);

    // A latency of 1 needs no counting, but keep at least one counter bit.
    localparam int CNT_W = (FALU_LAT > 1) ? $clog2(FALU_LAT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [RD_W-1:0]   r_pend_rd;
    logic [RD_W-1:0]   w_pend_rd_nxt;

    logic w_can_issue;
    logic w_falu_req;
    logic w_issue;
    logic w_busy;
    logic w_cmp_1;
    logic w_cmp_2;
    logic w_struct_stall;
    logic w_raw_stall;
    logic w_waw_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_rd <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend_rd <= w_pend_rd_nxt;
        end
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE);
        w_can_issue = (r_state == ST_IDLE) | ((r_state == ST_DONE) & wb_ready);
        w_falu_req  = ex_valid & ex_falu_en & ~flush;
        // rst_n gating keeps falu_start low while reset is asserted, since
        // the state register alone would leave it open to EX inputs.
        w_issue     = w_falu_req & w_can_issue & rst_n;

        w_cmp_1        = w_busy & id_fp_rs1_en & (id_rs1 == r_pend_rd);
        w_cmp_2        = w_busy & id_fp_rs2_en & (id_rs2 == r_pend_rd);
        w_struct_stall = w_falu_req & ~w_can_issue;
        // No bypass: a reader still stalls on the writeback cycle itself.
        w_raw_stall    = w_cmp_1 | w_cmp_2;
        w_waw_stall    = w_busy & ex_valid & ex_fp_wr & (ex_rd == r_pend_rd);

        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_rd_nxt = r_pend_rd;

        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt   = ST_EXEC;
                    w_cnt_nxt     = C_CNT_LOAD;
                    w_pend_rd_nxt = ex_rd;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (w_issue) begin
                    // Back-to-back: old result retires while the new op starts.
                    w_state_nxt   = ST_EXEC;
                    w_cnt_nxt     = C_CNT_LOAD;
                    w_pend_rd_nxt = ex_rd;
                end else if (wb_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        falu_start = w_issue;
        falu_busy  = w_busy;
        wb_valid   = (r_state == ST_DONE);
        wb_rd      = (r_state == ST_DONE) ? r_pend_rd : '0;
        stall      = w_struct_stall | w_raw_stall | w_waw_stall;
    end

endmodule
`default_nettype wire

// File: tb/tb_falu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_falu_issue_ctrl
// Description : Directed vector bench for falu_issue_ctrl. One instance with
//               FALU_LAT=3 runs the vector table; a second with FALU_LAT=1
//               shares the inputs for the short-latency and WAW cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_falu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ex_valid, ex_falu_en, ex_fp_wr, flush;
    logic [4:0] ex_rd;
    logic       id_fp_rs1_en, id_fp_rs2_en;
    logic [4:0] id_rs1, id_rs2;
    logic       wb_ready;

    logic       start3, busy3, wv3, stall3;
    logic [4:0] wrd3;
    logic       start1, busy1, wv1, stall1;
    logic [4:0] wrd1;

    int n_cmp;
    int n_err;

    falu_issue_ctrl #(.FALU_LAT(3), .RD_W(5)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_falu_en(ex_falu_en),
        .ex_rd(ex_rd), .ex_fp_wr(ex_fp_wr), .flush(flush),
        .id_fp_rs1_en(id_fp_rs1_en), .id_fp_rs2_en(id_fp_rs2_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .wb_ready(wb_ready),
        .falu_start(start3), .falu_busy(busy3), .wb_valid(wv3),
        .wb_rd(wrd3), .stall(stall3)
    );

    falu_issue_ctrl #(.FALU_LAT(1), .RD_W(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_falu_en(ex_falu_en),
        .ex_rd(ex_rd), .ex_fp_wr(ex_fp_wr), .flush(flush),
        .id_fp_rs1_en(id_fp_rs1_en), .id_fp_rs2_en(id_fp_rs2_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .wb_ready(wb_ready),
        .falu_start(start1), .falu_busy(busy1), .wb_valid(wv1),
        .wb_rd(wrd1), .stall(stall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ev, fe;
        logic [4:0] rd;
        logic       fw, fl, e1, e2;
        logic [4:0] r1, r2;
        logic       wr;
        logic       st, bz, wv;
        logic [4:0] wrd;
        logic       sl;
    } vec_t;

    function automatic vec_t v(
        input logic ev, input logic fe, input logic [4:0] rd, input logic fw,
        input logic fl, input logic e1, input logic e2, input logic [4:0] r1,
        input logic [4:0] r2, input logic wr, input logic st, input logic bz,
        input logic wv, input logic [4:0] wrd, input logic sl);
        vec_t t;
        t.ev = ev; t.fe = fe; t.rd = rd; t.fw = fw; t.fl = fl;
        t.e1 = e1; t.e2 = e2; t.r1 = r1; t.r2 = r2; t.wr = wr;
        t.st = st; t.bz = bz; t.wv = wv; t.wrd = wrd; t.sl = sl;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_falu_en = 0; ex_rd = 0; ex_fp_wr = 0; flush = 0;
        id_fp_rs1_en = 0; id_fp_rs2_en = 0; id_rs1 = 0; id_rs2 = 0;
        wb_ready = 1;
    endtask

    vec_t vecs[28];

    initial begin
        n_cmp = 0;
        n_err = 0;

        //            ev fe rd fw fl e1 e2 r1 r2 wr | st bz wv wrd sl
        // issue rd=5, writeback at T+4
        vecs[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 5, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        vecs[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 5, 0);
        vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        // rd=9 held in DONE for 3 blocked cycles; rd=7 op stalls then issues back-to-back
        vecs[7]  = v(1, 1, 9, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[11] = v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 9, 1);
        vecs[12] = v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 9, 1);
        vecs[13] = v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 9, 1);
        vecs[14] = v(1, 1, 7, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 9, 0);
        // RAW on rs2=7 through the writeback cycle, clear afterwards
        vecs[15] = v(0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 1, 0, 0, 1);
        vecs[16] = v(0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 1, 0, 0, 1);
        vecs[17] = v(0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 1, 0, 0, 1);
        vecs[18] = v(0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 1, 1, 7, 1);
        vecs[19] = v(0, 0, 0, 0, 0, 0, 1, 0, 7, 1,  0, 0, 0, 0, 0);
        // flushed op in IDLE: no start, no stall, stays idle
        vecs[20] = v(1, 1, 2, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
        // rd=7 again: disabled reads and non-matching FP write don't stall,
        // flushed op during EXEC doesn't stall, rs1 match does, result still written
        vecs[22] = v(1, 1, 7, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
        vecs[23] = v(1, 0, 4, 1, 0, 0, 0, 7, 7, 1,  0, 1, 0, 0, 0);
        vecs[24] = v(1, 1, 6, 0, 1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        vecs[25] = v(0, 0, 0, 0, 0, 1, 0, 7, 0, 1,  0, 1, 0, 0, 1);
        vecs[26] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 7, 0);
        vecs[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

        // Reset state
        idle_inputs();
        rst_n = 0;
        #3;
        check("rst_busy", busy3, 0);
        check("rst_wv", wv3, 0);
        check("rst_stall", stall3, 0);
        check("rst_start", start3, 0);
        #9 rst_n = 1;
        @(posedge clk); #1;

        // Table
        for (int i = 0; i < 28; i++) begin
            ex_valid = vecs[i].ev; ex_falu_en = vecs[i].fe; ex_rd = vecs[i].rd;
            ex_fp_wr = vecs[i].fw; flush = vecs[i].fl;
            id_fp_rs1_en = vecs[i].e1; id_fp_rs2_en = vecs[i].e2;
            id_rs1 = vecs[i].r1; id_rs2 = vecs[i].r2; wb_ready = vecs[i].wr;
            #2;
            check($sformatf("v%0d_start", i), start3, vecs[i].st);
            check($sformatf("v%0d_busy", i), busy3, vecs[i].bz);
            check($sformatf("v%0d_wv", i), wv3, vecs[i].wv);
            if (vecs[i].wv)
                check($sformatf("v%0d_wrd", i), wrd3, vecs[i].wrd);
            check($sformatf("v%0d_stall", i), stall3, vecs[i].sl);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-EXEC
        idle_inputs();
        ex_valid = 1; ex_falu_en = 1; ex_rd = 5;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #3;
        ex_valid = 1; ex_falu_en = 1; ex_rd = 8;
        #1;
        check("pre_rst_busy", busy3, 1);
        check("pre_rst_stall", stall3, 1);
        rst_n = 0;
        #1;
        check("arst_busy", busy3, 0);
        check("arst_wv", wv3, 0);
        check("arst_stall", stall3, 0);
        check("arst_start", start3, 0);
        check("arst_start_l1", start1, 0);
        @(posedge clk); #2;
        idle_inputs();
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_wv_%0d", c), wv3, 0);
            check($sformatf("post_rst_busy_%0d", c), busy3, 0);
        end

        // FALU_LAT=1 timing and WAW against a pending FLW destination
        ex_valid = 1; ex_falu_en = 1; ex_rd = 12;
        #2;
        check("l1_start", start1, 1);
        @(posedge clk); #1;
        ex_valid = 1; ex_falu_en = 0; ex_fp_wr = 1; ex_rd = 12;
        #1;
        check("l1_t1_busy", busy1, 1);
        check("l1_t1_wv", wv1, 0);
        check("l1_t1_waw", stall1, 1);
        @(posedge clk); #1;
        check("l1_t2_wv", wv1, 1);
        check("l1_t2_wrd", wrd1, 12);
        check("l1_t2_waw", stall1, 1);
        @(posedge clk); #1;
        check("l1_t3_busy", busy1, 0);
        check("l1_t3_wv", wv1, 0);
        check("l1_t3_stall", stall1, 0);

        idle_inputs();
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
